// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// codes, FSM state encoding and small decode helpers used by the fault logic.
package dmem_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'd0;
  localparam logic [2:0] FUNCT3_LH  = 3'd1;
  localparam logic [2:0] FUNCT3_LW  = 3'd2;
  localparam logic [2:0] FUNCT3_LBU = 3'd4;
  localparam logic [2:0] FUNCT3_LHU = 3'd5;
  localparam logic [2:0] FUNCT3_SB  = 3'd0;
  localparam logic [2:0] FUNCT3_SH  = 3'd1;
  localparam logic [2:0] FUNCT3_SW  = 3'd2;

  localparam int unsigned DMEM_DEPTH_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Loads reject funct3 3/6/7; stores accept only SB/SH/SW.
  function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
    logic bad;
    if (we) begin
      bad = (funct3 > FUNCT3_SW);
    end else begin
      bad = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    end
    return bad;
  endfunction

  // funct3[1:0] encodes access size for both loads and stores.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    case (funct3[1:0])
      2'd1:    bad = addr_lo[0];
      2'd2:    bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational little-endian lane steering: store mask/data replication and
// load byte/half extraction with sign or zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = rword[{addr_lo, 3'b000} +: 8];
  assign half_s = rword[{addr_lo[1], 4'b0000} +: 16];

  // Store side: replicate data across lanes, the mask picks the live ones.
  always_comb begin
    wmask      = 4'b0000;
    wdata_lane = wdata;
    case (funct3)
      FUNCT3_SB: begin
        wmask      = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      FUNCT3_SH: begin
        if (addr_lo[1]) begin
          wmask = 4'b1100;
        end else begin
          wmask = 4'b0011;
        end
        wdata_lane = {2{wdata[15:0]}};
      end
      FUNCT3_SW: begin
        wmask      = 4'b1111;
        wdata_lane = wdata;
      end
      default: begin
        wmask      = 4'b0000;
        wdata_lane = wdata;
      end
    endcase
  end

  // Load side extraction and extension.
  always_comb begin
    rdata_ext = 32'h0000_0000;
    case (funct3)
      FUNCT3_LB:  rdata_ext = {{24{byte_s[7]}}, byte_s};
      FUNCT3_LH:  rdata_ext = {{16{half_s[15]}}, half_s};
      FUNCT3_LW:  rdata_ext = rword;
      FUNCT3_LBU: rdata_ext = {24'h00_0000, byte_s};
      FUNCT3_LHU: rdata_ext = {16'h0000, half_s};
      default:    rdata_ext = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with programmable response latency,
// an internal little-endian byte array and acceptance-time fault checks.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned          AWIDTH      = 32,
  parameter int unsigned          DWIDTH      = 32,
  parameter logic [AWIDTH-1:0]    BASE_ADDR   = 32'h0100_0000,
  parameter int unsigned          DEPTH_BYTES = DMEM_DEPTH_DEFAULT,
  parameter int unsigned          LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int IDXW = $clog2(DEPTH_BYTES);
  localparam int CNTW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  dmem_state_e       state_r;
  logic [CNTW-1:0]   cnt_r;
  logic              rsp_valid_r;
  logic [31:0]       rsp_rdata_r;
  logic              rsp_err_r;

  logic [7:0]        mem_r [DEPTH_BYTES];

  logic [AWIDTH-1:0] offset_s;
  logic              fault_s;
  logic              accept_s;
  logic [IDXW-1:0]   base_s;
  logic [31:0]       rword_s;
  logic [3:0]        wmask_s;
  logic [31:0]       wdata_lane_s;
  logic [31:0]       rdata_ext_s;

  // Addresses below BASE_ADDR wrap to a huge offset and fail the range check.
  assign offset_s = req_addr_i - BASE_ADDR;
  assign fault_s  = (offset_s >= AWIDTH'(DEPTH_BYTES))
                  | misaligned(req_funct3_i, req_addr_i[1:0])
                  | funct3_illegal(req_we_i, req_funct3_i);
  assign accept_s = (state_r == IDLE) && req_valid_i && !rst;
  assign base_s   = offset_s[IDXW-1:0] & ~IDXW'(3);
  assign rword_s  = {mem_r[base_s + IDXW'(3)], mem_r[base_s + IDXW'(2)],
                     mem_r[base_s + IDXW'(1)], mem_r[base_s]};

  assign req_ready_o = (state_r == IDLE) && !rst;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_rdata_o = rsp_rdata_r;
  assign rsp_err_o   = rsp_err_r;

  dmem_lane_align u_align (
    .addr_lo    (req_addr_i[1:0]),
    .funct3     (req_funct3_i),
    .wdata      (req_wdata_i),
    .rword      (rword_s),
    .wmask      (wmask_s),
    .wdata_lane (wdata_lane_s),
    .rdata_ext  (rdata_ext_s)
  );

  // Byte array: written at the store's acceptance edge, never reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (accept_s && req_we_i && !fault_s && wmask_s[k]) begin
        mem_r[base_s + IDXW'(k)] <= wdata_lane_s[8*k +: 8];
      end
    end
  end

  // Request/response FSM with latency counter and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid_i) begin
            rsp_err_r <= fault_s;
            if (fault_s || req_we_i) begin
              rsp_rdata_r <= 32'h0000_0000;
            end else begin
              rsp_rdata_r <= rdata_ext_s;
            end
            if (LATENCY == 1) begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
            end else begin
              state_r <= WAIT;
              cnt_r   <= CNTW'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt_r == '0) begin
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNTW'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: a LATENCY=2 instance for function/fault/backpressure/reset
// and a LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam int unsigned DEPTH = 1024;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk, rst;
  int   checks, errors, cyc;
  exp_t q0[$];
  exp_t q1[$];

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [2:0]  req_funct3;

  logic        req_valid1, req_ready1, req_we1, rsp_valid1, rsp_ready1, rsp_err1;
  logic [31:0] req_addr1, req_wdata1, rsp_rdata1;
  logic [2:0]  req_funct31;

  dmem_responder #(.AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE), .DEPTH_BYTES(DEPTH), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  dmem_responder #(.AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE), .DEPTH_BYTES(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid1), .req_ready_o(req_ready1),
    .req_addr_i(req_addr1), .req_wdata_i(req_wdata1), .req_we_i(req_we1),
    .req_funct3_i(req_funct31), .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready1),
    .rsp_rdata_o(rsp_rdata1), .rsp_err_o(rsp_err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Monitors: pop and compare on every response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (q0.size() == 0) begin
        check("l2_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        check("l2_rdata", rsp_rdata, e.rdata);
        check("l2_err", {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
    if (rsp_valid1 === 1'b1 && rsp_ready1 === 1'b1) begin
      if (q1.size() == 0) begin
        check("l1_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        check("l1_rdata", rsp_rdata1, e.rdata);
        check("l1_err", {31'd0, rsp_err1}, {31'd0, e.err});
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  // Full transaction on the LATENCY=2 instance with latency measurement.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee);
    int n;
    wait_ready();
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    q0.push_back(exp_t'{rdata: er, err: ee});
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 32'd2);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] er;
  } vec_t;

  vec_t l1v[8];

  initial begin
    int n, acc, prev;
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
    req_valid1 = 1'b0; req_we1 = 1'b0; req_funct31 = 3'd0; req_addr1 = 32'd0; req_wdata1 = 32'd0; rsp_ready1 = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_req_ready1", {31'd0, req_ready1}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Store/load, extension, lane placement
    issue(1'b1, 3'd2, BASE + 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    issue(1'b0, 3'd2, BASE + 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    issue(1'b1, 3'd0, BASE + 32'h20, 32'h0000_005A, 32'h0, 1'b0);
    issue(1'b1, 3'd0, BASE + 32'h21, 32'h1234_5680, 32'h0, 1'b0);
    issue(1'b0, 3'd0, BASE + 32'h21, 32'h0, 32'hFFFF_FF80, 1'b0);
    issue(1'b0, 3'd4, BASE + 32'h21, 32'h0, 32'h0000_0080, 1'b0);
    issue(1'b0, 3'd1, BASE + 32'h20, 32'h0, 32'hFFFF_805A, 1'b0);
    issue(1'b0, 3'd5, BASE + 32'h20, 32'h0, 32'h0000_805A, 1'b0);
    issue(1'b1, 3'd1, BASE + 32'h22, 32'h5555_7F01, 32'h0, 1'b0);
    issue(1'b0, 3'd2, BASE + 32'h20, 32'h0, 32'h7F01_805A, 1'b0);
    // Faults leave the target word intact
    issue(1'b1, 3'd2, BASE + 32'h00, 32'h1122_3344, 32'h0, 1'b0);
    issue(1'b0, 3'd2, BASE + 32'h02, 32'h0, 32'h0, 1'b1);
    issue(1'b1, 3'd1, BASE + 32'h01, 32'h0000_FFFF, 32'h0, 1'b1);
    issue(1'b0, 3'd2, BASE + DEPTH, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 3'd3, BASE + 32'h00, 32'h0, 32'h0, 1'b1);
    issue(1'b1, 3'd3, BASE + 32'h00, 32'hFFFF_FFFF, 32'h0, 1'b1);
    issue(1'b0, 3'd2, BASE - 32'd4, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 3'd2, BASE + 32'h00, 32'h0, 32'h1122_3344, 1'b0);
    issue(1'b0, 3'd0, BASE + 32'h03, 32'h0, 32'h0000_0011, 1'b0);
    issue(1'b0, 3'd1, BASE + 32'h02, 32'h0, 32'h0000_1122, 1'b0);
    issue(1'b1, 3'd2, BASE + DEPTH - 32'd4, 32'h0BAD_F00D, 32'h0, 1'b0);
    issue(1'b0, 3'd2, BASE + DEPTH - 32'd4, 32'h0, 32'h0BAD_F00D, 1'b0);

    // Backpressure: response held 5 cycles while a competing store is offered
    issue(1'b1, 3'd2, BASE + 32'h30, 32'hA5A5_5A5A, 32'h0, 1'b0);
    rsp_ready = 1'b0;
    wait_ready();
    req_we = 1'b0; req_funct3 = 3'd2; req_addr = BASE + 32'h30; req_valid = 1'b1;
    q0.push_back(exp_t'{rdata: 32'hA5A5_5A5A, err: 1'b0});
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      req_we = 1'b1; req_wdata = 32'hFFFF_FFFF; req_valid = 1'b1;
      @(negedge clk);
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rdata", rsp_rdata, 32'hA5A5_5A5A);
      check("bp_err", {31'd0, rsp_err}, 32'd0);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_we = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 3'd2, BASE + 32'h30, 32'h0, 32'hA5A5_5A5A, 1'b0);

    // Async reset in WAIT after a store; the write must survive
    wait_ready();
    req_we = 1'b1; req_funct3 = 3'd2; req_addr = BASE + 32'h40; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_wait_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_wait_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_wait_release_ready", {31'd0, req_ready}, 32'd1);
    issue(1'b0, 3'd2, BASE + 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0);

    // Async reset while a response is stalled in RESP drops it at once
    rsp_ready = 1'b0;
    wait_ready();
    req_we = 1'b0; req_funct3 = 3'd2; req_addr = BASE + 32'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("resp_before_rst_valid", {31'd0, rsp_valid}, 32'd1);
    check("resp_before_rst_rdata", rsp_rdata, 32'hDEAD_BEEF);
    #2 rst = 1'b1;
    #1;
    check("rst_resp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_resp_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;

    // LATENCY=1 back-to-back with valid held high
    l1v[0] = '{1'b1, 3'd2, BASE + 32'h0, 32'h1111_1111, 32'h0};
    l1v[1] = '{1'b1, 3'd2, BASE + 32'h4, 32'h2222_2222, 32'h0};
    l1v[2] = '{1'b1, 3'd1, BASE + 32'h8, 32'h0000_BEEF, 32'h0};
    l1v[3] = '{1'b0, 3'd2, BASE + 32'h0, 32'h0, 32'h1111_1111};
    l1v[4] = '{1'b0, 3'd2, BASE + 32'h4, 32'h0, 32'h2222_2222};
    l1v[5] = '{1'b0, 3'd5, BASE + 32'h8, 32'h0, 32'h0000_BEEF};
    l1v[6] = '{1'b0, 3'd1, BASE + 32'h8, 32'h0, 32'hFFFF_BEEF};
    l1v[7] = '{1'b0, 3'd4, BASE + 32'h9, 32'h0, 32'h0000_00BE};
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (req_ready1 !== 1'b1 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      req_we1 = l1v[i].we; req_funct31 = l1v[i].f3; req_addr1 = l1v[i].addr;
      req_wdata1 = l1v[i].wd; req_valid1 = 1'b1;
      q1.push_back(exp_t'{rdata: l1v[i].er, err: 1'b0});
      @(posedge clk); #1;
      acc = cyc;
      if (i > 0) check("l1_accept_gap", acc - prev, 32'd2);
      prev = acc;
      @(negedge clk);
      check("l1_rsp_next_cycle", {31'd0, rsp_valid1}, 32'd1);
      @(posedge clk); #1;
    end
    req_valid1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V core's load/store port: accepts one request at a time over a valid/ready handshake and performs a byte, half or word access, little-endian, to an internal byte array. After a programmable latency it returns sign- or zero-extended load data, or a store acknowledge, with an error flag. It sits between the core's memory-stage initiator and backing storage, and replaces the zero-latency unified-memory data path once the pipeline tolerates stalls.

## Interface
- AWIDTH, 32, address width
- DWIDTH, 32, data width; only 32 is supported
- BASE_ADDR, 32'h01000000, first mapped byte address
- DEPTH_BYTES, `MEM_DEPTH, mapped size in bytes; power of two, ≥4
- LATENCY, 2, cycles from acceptance to `rsp_valid_o`; ≥1
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  responder can accept
- req_addr_i  in  AWIDTH  byte address
- req_wdata_i  in  DWIDTH  store data, right-aligned
- req_we_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  RV32I load/store funct3
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  initiator takes the response
- rsp_rdata_o  out  DWIDTH  extended load data; 0 for stores and errors
- rsp_err_o  out  1  access faulted

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - `req_ready_o` = 1.
  - On `req_valid_i`, the request is accepted.
  - If LATENCY = 1, the FSM goes to RESP. Otherwise it goes to WAIT with the counter loaded to LATENCY-2.
- WAIT: the counter decrements each cycle. The FSM goes to RESP when the counter is 0.
- RESP:
  - `rsp_valid_o` = 1. Data and error are held stable until `rsp_ready_i`.
  - On the handshake the FSM returns to IDLE. There is no same-cycle re-acceptance.
- Only one request is outstanding at a time. `req_ready_o` is 0 in WAIT and RESP.
- Fault checks are evaluated at acceptance. Any single check makes the access a fault:
  - Offset out of range: offset = addr − BASE_ADDR (unsigned, AWIDTH wide) and offset ≥ DEPTH_BYTES. Addresses below BASE_ADDR wrap around to a large offset and therefore fault.
  - Misalignment: half access with addr[0] = 1, or word access with addr[1:0] ≠ 0.
  - Illegal funct3: a load with funct3 ∈ {3, 6, 7}, or a store with funct3 ∉ {0, 1, 2}.
- A faulting access writes nothing, returns `rsp_err_o` = 1 and returns `rsp_rdata_o` = 0.
- Stores:
  - Byte lanes are written at the acceptance edge. SB writes 1 lane, SH writes 2 and SW writes 4.
  - Data is taken from the low bits of `req_wdata_i`.
  - The response carries `rsp_rdata_o` = 0.
- Loads:
  - Bytes are read at the acceptance edge and the extended result is registered.
  - LB and LH sign-extend. LBU and LHU zero-extend. LW is not extended.
- Array contents are not reset.

## Timing
- Reset values:
  - State is IDLE and the counter is 0.
  - `rsp_valid_o` = 0, `rsp_rdata_o` = 0, `rsp_err_o` = 0.
  - `req_ready_o` = 0 while `rst` is high. It is 1 from the first cycle `rst` is low.
- Latency: with acceptance at edge N, `rsp_valid_o` rises after edge N+LATENCY-1, so it is visible in cycle N+LATENCY.
- Back-to-back throughput is one access per LATENCY+1 cycles when `rsp_ready_i` is held high.
- If `rsp_ready_i` is low in RESP, the FSM stays in RESP indefinitely with all outputs frozen.
- Reset mid-operation:
  - The FSM returns to IDLE and the response is dropped.
  - A store already accepted remains written.
- A store followed by a load to the same address returns the new data, because the write completes at the store's acceptance edge.

## Structure
- Shared package, alongside constants.svh:
  - FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU, FUNCT3_SB, FUNCT3_SH and FUNCT3_SW (reuse existing definitions).
  - `dmem_state_e` {IDLE, WAIT, RESP}.
- Sub-module `dmem_lane_align`, combinational. It produces:
  - the 4-bit write-lane mask and the lane-shifted write data from addr[1:0] and funct3;
  - the extracted and extended load result from the raw word, addr[1:0] and funct3.
- Top-level RTL holds the FSM, the latency counter, the byte array and the fault checks.

## Test plan
- Store then load, LATENCY = 2:
  - SW 32'hDEADBEEF at 32'h01000010, then LW at 32'h01000010.
  - Required: `rdata` = 32'hDEADBEEF, `err` = 0, and `rsp_valid_o` is seen exactly 2 cycles after each acceptance.
- Extension:
  - SB 8'h80 at 32'h01000021.
  - Required: LB returns 32'hFFFFFF80, LBU returns 32'h00000080, and LH at 32'h01000020 returns 32'hFFFF80xx with the low byte unchanged.
- Faults:
  - LW at 32'h01000002, SH at 32'h01000001, LW at BASE_ADDR+DEPTH_BYTES, and a load with funct3 = 3.
  - Required: each returns `err` = 1 and `rdata` = 0. A follow-up LW to the targeted words shows no change.
- Backpressure:
  - Hold `rsp_ready_i` = 0 for 5 cycles in RESP.
  - Required: `rsp_valid_o`, `rdata` and `err` are stable, `req_ready_o` = 0, and a new `req_valid_i` is not accepted.
- LATENCY = 1, back-to-back loads with `rsp_ready_i` high.
  - Required: one acceptance every 2 cycles and a response in the cycle after each acceptance.
- Async reset asserted in WAIT after a store.
  - Required: `rsp_valid_o` goes to 0 immediately. After release, a load of that address returns the stored data.
